switch_key_encoder: RTL and testbench

- Generalised switch-to-key front end for the calculator: NUM_SW slide switches, each mapped to a parameterised 5-bit key code in the standard key format (channel 0 default 5'b10001, the negative key).
- Synchronises, debounces and edge-detects every switch internally.
- Emits each press or release as one key event on a valid/ready output toward the key-pulse/entry logic.
- Per-channel pending slots with fixed priority; overflow is flagged.

---
 rtl/calc_key_pkg.sv | 19 +
 rtl/switch_debounce_channel.sv | 49 ++++
 rtl/switch_key_encoder.sv | 124 ++++++++++++
 tb/tb_switch_key_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_key_pkg.sv
// Shared key-format constants for the calculator key front end.
// Key codes are 5 bits wide; the all-zero code means "no key".
package calc_key_pkg;

  localparam int unsigned KEY_W = 5;

  localparam logic [KEY_W-1:0] KEY_NONE     = 5'b00000;
  localparam logic [KEY_W-1:0] KEY_NEGATIVE = 5'b10001;

  localparam logic EV_PRESS   = 1'b0;
  localparam logic EV_RELEASE = 1'b1;

  localparam int unsigned DEFAULT_NUM_SW = 4;

  // Channel 0 sits in the low bits.
  localparam logic [DEFAULT_NUM_SW*KEY_W-1:0] DEFAULT_CODES =
      {5'b10100, 5'b10011, 5'b10010, KEY_NEGATIVE};

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: 2-flop synchroniser, stability counter and edge strobes.
// rise/fall are asserted in the cycle before the edge that toggles level.
module switch_debounce_channel #(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic             sync1_q;
  logic             s_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             toggle;

  always_comb begin
    toggle  = (s_q != level_q) && (cnt_q == CNT_W'(DB_CYCLES - 1));
    level_d = level_q ^ toggle;
    if ((s_q == level_q) || toggle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_raw;
      s_q     <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = toggle & ~level_q;
  assign fall  = toggle & level_q;

endmodule

// File: rtl/switch_key_encoder.sv
// Switch-to-key front end: debounced switch edges become key events on a
// valid/ready output, one pending slot per channel, lowest index first.
module switch_key_encoder
  import calc_key_pkg::*;
#(
  parameter int unsigned            NUM_SW    = 4,
  parameter int unsigned            DB_CYCLES = 16,
  parameter logic [NUM_SW*KEY_W-1:0] CODES    = DEFAULT_CODES,
  parameter logic [NUM_SW-1:0]      RISE_MASK = '1,
  parameter logic [NUM_SW-1:0]      FALL_MASK = NUM_SW'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_SW-1:0] sw,
  input  logic             key_ready,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_code,
  output logic             key_release,
  output logic [NUM_SW-1:0] sw_state,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);

  logic [NUM_SW-1:0] rise, fall, ev;
  logic [NUM_SW-1:0] pend_q, pend_d;
  logic [NUM_SW-1:0] rel_q, rel_d;
  logic [NUM_SW-1:0] drain, drop;

  logic             valid_q, valid_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             krel_q, krel_d;
  logic             ovf_q, ovf_d;

  logic             load;
  logic             found;
  logic [KEY_W-1:0] sel_code;
  logic             sel_rel;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    switch_debounce_channel #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .sw_raw(sw[i]),
      .level (sw_state[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign ev   = (rise & RISE_MASK) | (fall & FALL_MASK);
  assign load = ~valid_q | key_ready;

  // Priority select over the registered slots only, so a fresh event waits a cycle.
  always_comb begin
    found    = 1'b0;
    sel_code = KEY_NONE;
    sel_rel  = EV_PRESS;
    drain    = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (!found && pend_q[i]) begin
        found    = 1'b1;
        sel_code = CODES[i*KEY_W +: KEY_W];
        sel_rel  = rel_q[i];
        drain[i] = load;
      end
    end
  end

  always_comb begin
    pend_d = pend_q & ~drain;
    rel_d  = rel_q;
    drop   = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (ev[i]) begin
        if (!pend_q[i] || drain[i]) begin
          pend_d[i] = 1'b1;
          rel_d[i]  = fall[i] ? EV_RELEASE : EV_PRESS;
        end else begin
          drop[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    krel_d  = krel_q;
    ovf_d   = |drop;
    if (load) begin
      valid_d = found;
      code_d  = sel_code;
      krel_d  = found & sel_rel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      rel_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= KEY_NONE;
      krel_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      krel_q  <= krel_d;
      ovf_q   <= ovf_d;
    end
  end

  assign key_valid   = valid_q;
  assign key_code    = code_q;
  assign key_release = krel_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_switch_key_encoder.sv
// Directed bench for switch_key_encoder with DB_CYCLES=4 and default codes/masks,
// followed by a short randomised toggle run checked against a per-channel scoreboard.
module tb_switch_key_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       key_ready;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_release;
  logic [3:0] sw_state;
  logic       overflow;

  int checks;
  int errors;
  int ovf_n;
  logic [5:0] acc_q[$];

  typedef struct {
    int   ch;
    logic rel;
  } ev_t;
  ev_t expq[$];

  switch_key_encoder #(
    .NUM_SW   (4),
    .DB_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_release(key_release),
    .sw_state   (sw_state),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted event and every overflow pulse.
  always @(posedge clk) begin
    if (!rst && key_valid && key_ready) acc_q.push_back({key_release, key_code});
    if (!rst && overflow) ovf_n <= ovf_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int chan_of(input logic [4:0] c);
    case (c)
      5'b10001: return 0;
      5'b10010: return 1;
      5'b10011: return 2;
      5'b10100: return 3;
      default:  return 7;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   base;
    int   ob;
    int   gen;
    int   ch;
    int   idx;
    logic [5:0] e;

    checks    = 0;
    errors    = 0;
    ovf_n     = 0;
    rst       = 1'b1;
    sw        = 4'b0000;
    key_ready = 1'b1;

    // Reset state
    step(2);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 5'b00000);
    check("rst_rel", key_release, 1'b0);
    check("rst_state", sw_state, 4'b0000);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    step(2);

    // sw[0] press: sw_state at edge 6, key_valid at edge 7 for one cycle
    sw[0] = 1'b1;
    step(5);
    check("press0_state_e5", sw_state[0], 1'b0);
    step(1);
    check("press0_state_e6", sw_state[0], 1'b1);
    check("press0_valid_e6", key_valid, 1'b0);
    step(1);
    check("press0_valid_e7", key_valid, 1'b1);
    check("press0_code", key_code, 5'b10001);
    check("press0_rel", key_release, 1'b0);
    step(1);
    check("press0_valid_e8", key_valid, 1'b0);
    check("press0_code_idle", key_code, 5'b00000);

    // sw[0] release produces a release event
    sw[0] = 1'b0;
    step(7);
    check("rel0_valid", key_valid, 1'b1);
    check("rel0_code", key_code, 5'b10001);
    check("rel0_rel", key_release, 1'b1);
    step(1);

    // Short glitch on sw[1] is filtered
    base  = acc_q.size();
    sw[1] = 1'b1;
    step(3);
    sw[1] = 1'b0;
    step(20);
    check("glitch_state", sw_state[1], 1'b0);
    check("glitch_no_event", acc_q.size() - base, 0);
    check("glitch_no_ovf", ovf_n, 0);

    // sw[1] press emits, release does not (FALL_MASK[1]=0)
    sw[1] = 1'b1;
    step(10);
    check("press1_state", sw_state[1], 1'b1);
    check("press1_count", acc_q.size() - base, 1);
    check("press1_event", acc_q[acc_q.size()-1], {1'b0, 5'b10010});
    sw[1] = 1'b0;
    step(10);
    check("rel1_state", sw_state[1], 1'b0);
    check("rel1_no_event", acc_q.size() - base, 1);

    // Simultaneous sw[3]/sw[1] with ready low: 10010 held, then 10010, 10100
    key_ready = 1'b0;
    base      = acc_q.size();
    sw[3]     = 1'b1;
    sw[1]     = 1'b1;
    step(7);
    check("stall_valid", key_valid, 1'b1);
    check("stall_code", key_code, 5'b10010);
    for (int k = 0; k < 20; k++) begin
      step(1);
      check("hold_valid", key_valid, 1'b1);
      check("hold_code", key_code, 5'b10010);
    end
    key_ready = 1'b1;
    step(1);
    check("b2b_valid", key_valid, 1'b1);
    check("b2b_code", key_code, 5'b10100);
    step(1);
    check("b2b_empty", key_valid, 1'b0);
    check("b2b_count", acc_q.size() - base, 2);
    check("b2b_first", acc_q[base], {1'b0, 5'b10010});
    check("b2b_second", acc_q[base+1], {1'b0, 5'b10100});
    sw[3] = 1'b0;
    sw[1] = 1'b0;
    step(10);

    // Overflow on sw[2]: one in output, one pending, third dropped
    key_ready = 1'b0;
    base      = acc_q.size();
    ob        = ovf_n;
    sw[2]     = 1'b1;
    step(7);
    check("ovf_first_valid", key_valid, 1'b1);
    check("ovf_first_code", key_code, 5'b10011);
    sw[2] = 1'b0;
    step(8);
    sw[2] = 1'b1;
    step(8);
    sw[2] = 1'b0;
    step(8);
    check("ovf_none_yet", ovf_n - ob, 0);
    sw[2] = 1'b1;
    step(8);
    check("ovf_one_pulse", ovf_n - ob, 1);
    check("ovf_code_held", key_code, 5'b10011);
    key_ready = 1'b1;
    step(5);
    check("ovf_two_events", acc_q.size() - base, 2);
    check("ovf_last_event", acc_q[acc_q.size()-1], {1'b0, 5'b10011});
    sw[2] = 1'b0;
    step(10);

    // Asynchronous reset with an event in flight and two pending
    key_ready = 1'b0;
    sw        = 4'b1011;
    step(8);
    check("pre_rst_valid", key_valid, 1'b1);
    check("pre_rst_code", key_code, 5'b10001);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", key_valid, 1'b0);
    check("async_rst_code", key_code, 5'b00000);
    check("async_rst_state", sw_state, 4'b0000);
    check("async_rst_ovf", overflow, 1'b0);
    sw = 4'b0000;
    step(2);
    rst       = 1'b0;
    key_ready = 1'b1;
    base      = acc_q.size();
    ob        = ovf_n;
    step(20);
    check("post_rst_no_event", acc_q.size() - base, 0);
    check("post_rst_no_ovf", ovf_n - ob, 0);

    // Random toggles, gaps >= 8 cycles, random ready
    base = acc_q.size();
    ob   = ovf_n;
    gen  = 0;
    for (int n = 0; n < 40; n++) begin
      ch     = int'($urandom_range(0, 3));
      sw[ch] = ~sw[ch];
      if (sw[ch]) begin
        expq.push_back('{ch: ch, rel: 1'b0});
        gen++;
      end else if (ch == 0) begin
        expq.push_back('{ch: ch, rel: 1'b1});
        gen++;
      end
      for (int k = 0; k < 8 + int'($urandom_range(0, 4)); k++) begin
        key_ready = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end
    key_ready = 1'b1;
    step(20);
    for (int j = base; j < acc_q.size(); j++) begin
      e   = acc_q[j];
      ch  = chan_of(e[4:0]);
      idx = -1;
      for (int m = 0; m < expq.size(); m++) begin
        if (idx < 0 && expq[m].ch == ch) idx = m;
      end
      check("rnd_matched", (idx >= 0), 1'b1);
      if (idx >= 0) begin
        check("rnd_rel", e[5], expq[idx].rel);
        expq.delete(idx);
      end
    end
    check("rnd_total", (acc_q.size() - base) + (ovf_n - ob), gen);
    check("rnd_leftover", expq.size(), ovf_n - ob);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
